// File: rtl/kb_matrix_pkg.sv
// Shared types and constants for the RX-78 keyboard/joystick matrix responder.
// The anchor scancodes are the fixed points that software and the bench rely on.
package kb_matrix_pkg;

  localparam int         NUM_COLS_DEF = 9;
  localparam logic [7:0] JOY1_SEL_DEF = 8'h30;
  localparam logic [7:0] JOY2_SEL_DEF = 8'h40;

  typedef struct packed {
    logic       hit;
    logic [3:0] col;
    logic [2:0] row;
  } kb_pos_t;

  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_RET   = 8'h5A;
  localparam logic [7:0] SC_UP    = 8'h75;  // E0-extended

  function automatic kb_pos_t kp(input logic [3:0] col, input logic [2:0] row);
    kp = '{hit: 1'b1, col: col, row: row};
  endfunction

endpackage

// File: rtl/kb_matrix_map.sv
// Combinational PS/2 set-2 {ext, scancode} to matrix position table.
// Codes not listed here return hit=0 and are ignored downstream.
module kb_map
  import kb_matrix_pkg::*;
(
  input  logic       ext_i,
  input  logic [7:0] code_i,
  output kb_pos_t    pos_o
);

  always_comb begin
    case ({ext_i, code_i})
      9'h045: pos_o = kp(4'd0, 3'd0);
      9'h016: pos_o = kp(4'd0, 3'd1);
      9'h01E: pos_o = kp(4'd0, 3'd2);
      9'h026: pos_o = kp(4'd0, 3'd3);
      9'h025: pos_o = kp(4'd0, 3'd4);
      9'h02E: pos_o = kp(4'd0, 3'd5);
      9'h036: pos_o = kp(4'd0, 3'd6);
      9'h03D: pos_o = kp(4'd0, 3'd7);
      9'h03E: pos_o = kp(4'd1, 3'd0);
      9'h046: pos_o = kp(4'd1, 3'd1);
      9'h04E: pos_o = kp(4'd1, 3'd2);
      9'h04C: pos_o = kp(4'd1, 3'd3);
      9'h041: pos_o = kp(4'd1, 3'd4);
      9'h049: pos_o = kp(4'd1, 3'd5);
      9'h04A: pos_o = kp(4'd1, 3'd6);
      9'h055: pos_o = kp(4'd1, 3'd7);
      9'h054: pos_o = kp(4'd2, 3'd0);
      {1'b0, SC_A}: pos_o = kp(4'd2, 3'd1);
      9'h032: pos_o = kp(4'd2, 3'd2);
      9'h021: pos_o = kp(4'd2, 3'd3);
      9'h023: pos_o = kp(4'd2, 3'd4);
      9'h024: pos_o = kp(4'd2, 3'd5);
      9'h02B: pos_o = kp(4'd2, 3'd6);
      9'h034: pos_o = kp(4'd2, 3'd7);
      9'h033: pos_o = kp(4'd3, 3'd0);
      9'h043: pos_o = kp(4'd3, 3'd1);
      9'h03B: pos_o = kp(4'd3, 3'd2);
      9'h042: pos_o = kp(4'd3, 3'd3);
      9'h04B: pos_o = kp(4'd3, 3'd4);
      9'h03A: pos_o = kp(4'd3, 3'd5);
      9'h031: pos_o = kp(4'd3, 3'd6);
      9'h044: pos_o = kp(4'd3, 3'd7);
      9'h04D: pos_o = kp(4'd4, 3'd0);
      9'h015: pos_o = kp(4'd4, 3'd1);
      9'h02D: pos_o = kp(4'd4, 3'd2);
      9'h01B: pos_o = kp(4'd4, 3'd3);
      9'h02C: pos_o = kp(4'd4, 3'd4);
      9'h03C: pos_o = kp(4'd4, 3'd5);
      9'h02A: pos_o = kp(4'd4, 3'd6);
      9'h01D: pos_o = kp(4'd4, 3'd7);
      9'h022: pos_o = kp(4'd5, 3'd0);
      9'h035: pos_o = kp(4'd5, 3'd1);
      9'h01A: pos_o = kp(4'd5, 3'd2);
      9'h05B: pos_o = kp(4'd5, 3'd3);
      9'h05D: pos_o = kp(4'd5, 3'd4);
      9'h052: pos_o = kp(4'd5, 3'd5);
      9'h00E: pos_o = kp(4'd5, 3'd6);
      9'h066: pos_o = kp(4'd5, 3'd7);
      9'h00D: pos_o = kp(4'd6, 3'd0);
      9'h076: pos_o = kp(4'd6, 3'd1);
      {1'b0, SC_RET}: pos_o = kp(4'd7, 3'd0);
      9'h014: pos_o = kp(4'd7, 3'd5);
      9'h012: pos_o = kp(4'd7, 3'd6);
      9'h059: pos_o = kp(4'd7, 3'd7);
      {1'b0, SC_SPACE}: pos_o = kp(4'd8, 3'd0);
      9'h170: pos_o = kp(4'd8, 3'd1);
      9'h171: pos_o = kp(4'd8, 3'd2);
      {1'b1, SC_UP}: pos_o = kp(4'd8, 3'd4);
      9'h172: pos_o = kp(4'd8, 3'd5);
      9'h16B: pos_o = kp(4'd8, 3'd6);
      9'h174: pos_o = kp(4'd8, 3'd7);
      // F1 sits on an extension column that the 9-column build does not have.
      9'h005: pos_o = kp(4'd9, 3'd0);
      default: pos_o = '0;
    endcase
  end

endmodule

// File: rtl/kb_matrix.sv
// PS/2 event pipeline (edge -> map -> apply) into a held key matrix, plus the
// registered port-F4 read path returning a matrix column or a joystick word.
module kb_matrix
  import kb_matrix_pkg::*;
#(
  parameter int         NUM_COLS = NUM_COLS_DEF,
  parameter logic [7:0] JOY1_SEL = JOY1_SEL_DEF,
  parameter logic [7:0] JOY2_SEL = JOY2_SEL_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [7:0]  col_sel,
  input  logic        clr_all,
  input  logic [31:0] joy1,
  input  logic [31:0] joy2,
  output logic [7:0]  kb_rows,
  output logic        evt_valid
);

  localparam logic [7:0] LAST_SEL  = 8'(NUM_COLS);
  localparam logic [3:0] COL_LIMIT = 4'(NUM_COLS);

  logic                     armed_q, tog_q, new_evt;
  logic                     s0_vld_q;
  logic [9:0]               s0_key_q;
  logic                     s1_vld_q, s1_press_q;
  kb_pos_t                  map_pos, s1_pos_q;
  logic [NUM_COLS-1:0][7:0] matrix_q, matrix_d;
  logic                     evt_d, evt_q;
  logic [7:0]               rows_d, rows_q;
  logic [3:0]               rd_col;
  logic                     unused_joy_bits;

  // armed_q stays low for the first clock after reset so a toggle bit that was
  // already set while in reset is absorbed instead of becoming an event.
  assign new_evt = armed_q && (ps2_key[10] != tog_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_q  <= 1'b0;
      tog_q    <= 1'b0;
      s0_vld_q <= 1'b0;
      s0_key_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so each stage samples the previous
      // stage's old value at the same edge and the pipeline shifts cleanly.
      armed_q  <= 1'b1;
      tog_q    <= ps2_key[10];
      s0_vld_q <= new_evt;
      if (new_evt) s0_key_q <= ps2_key[9:0];
    end
  end

  kb_map u_map (
    .ext_i  (s0_key_q[8]),
    .code_i (s0_key_q[7:0]),
    .pos_o  (map_pos)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q   <= 1'b0;
      s1_press_q <= 1'b0;
      s1_pos_q   <= '0;
    end else begin
      s1_vld_q   <= s0_vld_q;
      s1_press_q <= s0_key_q[9];
      s1_pos_q   <= map_pos;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns matrix_d and evt_d and no
    // latch is inferred.
    matrix_d = matrix_q;
    evt_d    = 1'b0;
    if (clr_all) begin
      matrix_d = '0;
    end else if (s1_vld_q && s1_pos_q.hit && (s1_pos_q.col < COL_LIMIT)) begin
      matrix_d[s1_pos_q.col][s1_pos_q.row] = s1_press_q;
      evt_d = 1'b1;
    end
  end

  assign rd_col = 4'(col_sel - 8'd1);

  always_comb begin
    rows_d = 8'h00;
    if ((col_sel != 8'd0) && (col_sel <= LAST_SEL)) rows_d = matrix_q[rd_col];
    else if (col_sel == JOY1_SEL)                   rows_d = {2'b00, joy1[5:0]};
    else if (col_sel == JOY2_SEL)                   rows_d = {2'b00, joy2[5:0]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the matrix is built from flops and must read all-released out of
      // reset, so it is reset with everything else rather than left as RAM.
      matrix_q <= '0;
      evt_q    <= 1'b0;
      rows_q   <= 8'h00;
    end else begin
      matrix_q <= matrix_d;
      evt_q    <= evt_d;
      rows_q   <= rows_d;
    end
  end

  assign kb_rows         = rows_q;
  assign evt_valid       = evt_q;
  assign unused_joy_bits = ^{joy1[31:6], joy2[31:6]};

endmodule

// File: tb/tb_kb_matrix.sv
// Directed bench for kb_matrix: an event-queue model of the key matrix checked
// every cycle, plus literal expectations at the scenario points.
module tb_kb_matrix;
  import kb_matrix_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [7:0]  col_sel;
  logic        clr_all;
  logic [31:0] joy1, joy2;
  logic [7:0]  kb_rows;
  logic        evt_valid;

  int tests_run = 0;
  int tests_failed = 0;

  kb_matrix dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_key   (ps2_key),
    .col_sel   (col_sel),
    .clr_all   (clr_all),
    .joy1      (joy1),
    .joy2      (joy2),
    .kb_rows   (kb_rows),
    .evt_valid (evt_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    bit         press;
    bit         ext;
    logic [7:0] code;
  } ev_t;

  ev_t        pend[$];
  logic [7:0] mdl_mat[9];
  int         edge_no;
  bit         mdl_armed;
  bit         mdl_tog;
  logic [7:0] exp_rows;
  logic       exp_evt;

  // Positions of the codes this bench sends; anything else is unmapped.
  task automatic bench_map(input bit ext, input logic [7:0] code,
                           output bit hit, output int col, output int row);
    hit = 1'b1; col = 0; row = 0;
    case ({ext, code})
      9'h01C: begin col = 2; row = 1; end
      9'h029: begin col = 8; row = 0; end
      9'h05A: begin col = 7; row = 0; end
      9'h175: begin col = 8; row = 4; end
      9'h005: begin col = 9; row = 0; end
      default: hit = 1'b0;
    endcase
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      edge_no   = 0;
      mdl_armed = 1'b0;
      mdl_tog   = 1'b0;
      pend.delete();
      for (int i = 0; i < 9; i++) mdl_mat[i] = 8'h00;
      exp_rows  = 8'h00;
      exp_evt   = 1'b0;
    end else begin
      check("model_rows", kb_rows, exp_rows);
      check("model_evt", {7'b0, evt_valid}, {7'b0, exp_evt});
      // Predict the outputs after the coming edge from the inputs it will see.
      edge_no++;
      begin
        int c;
        c = int'(col_sel);
        if (c >= 1 && c <= 9)   exp_rows = mdl_mat[c-1];
        else if (c == 8'h30)    exp_rows = {2'b00, joy1[5:0]};
        else if (c == 8'h40)    exp_rows = {2'b00, joy2[5:0]};
        else                    exp_rows = 8'h00;
      end
      exp_evt = 1'b0;
      while (pend.size() > 0 && pend[0].due == edge_no) begin
        ev_t e;
        bit  hit;
        int  col, row;
        e = pend.pop_front();
        bench_map(e.ext, e.code, hit, col, row);
        if (!clr_all && hit && col < 9) begin
          mdl_mat[col][row] = e.press;
          exp_evt = 1'b1;
        end
      end
      if (clr_all)
        for (int i = 0; i < 9; i++) mdl_mat[i] = 8'h00;
      if (mdl_armed && (ps2_key[10] != mdl_tog))
        pend.push_back('{due: edge_no + 2, press: ps2_key[9], ext: ps2_key[8], code: ps2_key[7:0]});
      mdl_tog   = ps2_key[10];
      mdl_armed = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit press, input bit ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], press, ext, code};
    step();
  endtask

  task automatic sweep_zero(input string name);
    for (int c = 1; c <= 9; c++) begin
      col_sel = 8'(c);
      step();
      check(name, kb_rows, 8'h00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    ps2_key = 11'h400;
    col_sel = 8'd3;
    clr_all = 1'b0;
    joy1    = '0;
    joy2    = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Stale toggle at reset release must not create an event.
    repeat (3) step();
    check("reset_evt", {7'b0, evt_valid}, 8'h00);
    check("reset_rows", kb_rows, 8'h00);

    // Press A: evt at N+2, row word at N+3; then release.
    send(1'b1, 1'b0, SC_A);
    step(); step();
    check("a_press_evt", {7'b0, evt_valid}, 8'h01);
    step();
    check("a_press_rows", kb_rows, 8'h02);
    send(1'b0, 1'b0, SC_A);
    step(); step();
    check("a_release_evt", {7'b0, evt_valid}, 8'h01);
    step();
    check("a_release_rows", kb_rows, 8'h00);

    // Back-to-back SPACE and cursor-up on column 9.
    col_sel = 8'd9;
    send(1'b1, 1'b0, SC_SPACE);
    send(1'b1, 1'b1, SC_UP);
    step();
    check("b2b_evt1", {7'b0, evt_valid}, 8'h01);
    step();
    check("b2b_evt2", {7'b0, evt_valid}, 8'h01);
    check("b2b_rows_mid", kb_rows, 8'h01);
    step();
    check("b2b_rows", kb_rows, 8'h11);

    // Clear, then an unmapped code leaves every column empty.
    clr_all = 1'b1;
    step();
    clr_all = 1'b0;
    send(1'b1, 1'b0, 8'h07);
    step(); step();
    check("unmapped_evt", {7'b0, evt_valid}, 8'h00);
    sweep_zero("unmapped_cols");

    // Hold A and RET, then clr_all on the cycle SPACE reaches the apply stage.
    col_sel = 8'd3;
    send(1'b1, 1'b0, SC_A);
    send(1'b1, 1'b0, SC_RET);
    step(); step();
    check("held_a", kb_rows, 8'h02);
    col_sel = 8'd8;
    step();
    check("held_ret", kb_rows, 8'h01);
    send(1'b1, 1'b0, SC_SPACE);
    step();
    clr_all = 1'b1;
    step();
    clr_all = 1'b0;
    check("clr_evt", {7'b0, evt_valid}, 8'h00);
    sweep_zero("clr_cols");

    // An event still in stage 1 when clr_all hits survives the clear.
    col_sel = 8'd3;
    send(1'b1, 1'b0, SC_SPACE);
    send(1'b1, 1'b0, SC_A);
    clr_all = 1'b1;
    step();
    clr_all = 1'b0;
    check("post_clr_drop", {7'b0, evt_valid}, 8'h00);
    step();
    check("post_clr_evt", {7'b0, evt_valid}, 8'h01);
    step();
    check("post_clr_a", kb_rows, 8'h02);
    col_sel = 8'd9;
    step();
    check("post_clr_space", kb_rows, 8'h00);

    // Column beyond NUM_COLS is dropped silently.
    send(1'b1, 1'b0, 8'h05);
    step(); step();
    check("oob_col_evt", {7'b0, evt_valid}, 8'h00);

    // Repeat press of held A and release of unheld RET still pulse evt_valid.
    col_sel = 8'd3;
    send(1'b1, 1'b0, SC_A);
    send(1'b0, 1'b0, SC_RET);
    step();
    check("repeat_evt", {7'b0, evt_valid}, 8'h01);
    step();
    check("unheld_evt", {7'b0, evt_valid}, 8'h01);
    check("repeat_rows", kb_rows, 8'h02);

    // Joystick selects and out-of-range selects.
    joy1    = 32'hFFFF_FF11;
    col_sel = 8'h30;
    step();
    check("joy1", kb_rows, 8'h11);
    col_sel = 8'h40;
    step();
    check("joy2_zero", kb_rows, 8'h00);
    joy2 = 32'h0000_002A;
    step();
    check("joy2_bits", kb_rows, 8'h2A);
    col_sel = 8'h0A;
    step();
    check("sel_beyond", kb_rows, 8'h00);
    col_sel = 8'h00;
    step();
    check("sel_zero", kb_rows, 8'h00);

    repeat (4) step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/kb_matrix.md
Name: kb_matrix

Overview:
- Keyboard/joystick responder for the RX-78 I/O port F4 read path.
- The CPU side writes a column-select byte and reads back an 8-bit row word.
- This block turns the host PS/2 event stream (ps2_key) and MiSTer joystick words into a held key matrix.
- It answers column selects with registered row data and replaces the ad-hoc keyboard decode inside the top level.

Parameters:
- NUM_COLS, 9, number of keyboard matrix columns (select codes 1..NUM_COLS).
- JOY1_SEL, 8'h30, select code that returns joystick 1 state.
- JOY2_SEL, 8'h40, select code that returns joystick 2 state.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ps2_key  in  11  [10] toggles on each event, [9] 1=press/0=release, [8] E0-extended, [7:0] scancode.
- col_sel  in  8  column-select byte last written to port F4.
- clr_all  in  1  synchronous pulse: release every key (OSD focus loss / core reset).
- joy1  in  32  MiSTer joystick 1; [0]R [1]L [2]D [3]U [4]fire1 [5]fire2.
- joy2  in  32  joystick 2, same layout.
- kb_rows  out  8  row word for col_sel, active-high (1 = pressed).
- evt_valid  out  1  one-cycle pulse when a mapped key changed the matrix.

Behaviour:
- Reset (async, reset_n=0):
  - matrix all 0, kb_rows=8'h00, evt_valid=0.
  - Toggle tracker is loaded with ps2_key[10] on the first clock after release, so a stale toggle creates no event.
- Stage 0 (edge): a new event is detected when ps2_key[10] differs from the tracked copy. Capture {ps2_key[9:0]} and update the tracked copy.
- Stage 1 (map): the kb_map lookup on {ext, scancode} yields hit, col (4b, 0-based) and row (3b). Register them.
- Stage 2 (apply): if hit and col < NUM_COLS, set matrix[col][row] to the press bit and pulse evt_valid. An unmapped or out-of-range code is dropped silently with no evt_valid.
- Latency: ps2_key toggle at edge N gives the matrix update at edge N+2. kb_rows reflects it at edge N+3 if col_sel is already stable.
- Throughput: one event per clock; the pipeline never stalls, and back-to-back toggles are each processed.
- Repeat press of a held key: matrix is unchanged, evt_valid still pulses. Release of an unheld key behaves the same way.
- Read path, registered each clock:
  - col_sel in 1..NUM_COLS → matrix[col_sel-1].
  - col_sel==JOY1_SEL → {2'b0, joy1[5], joy1[4], joy1[3], joy1[2], joy1[1], joy1[0]}.
  - col_sel==JOY2_SEL → same layout from joy2.
  - any other value, including 0 → 8'h00.
  - Latency from col_sel change to kb_rows is 1 clock.
- Shift keys are ordinary matrix positions; there is no modifier translation.
- clr_all clears the whole matrix at the next edge and has priority over a stage-2 apply in the same cycle (that apply is discarded, evt_valid=0). Events already in stages 0/1 proceed normally afterwards.
- Reset mid-event: pipeline registers are cleared and the event is lost. This is acceptable.

Decomposition:
- Package kb_matrix_pkg holds:
  - NUM_COLS default.
  - Select-code constants.
  - The key-position type {hit, col[3:0], row[2:0]}.
  - Anchor scancode constants used by the bench: SC_A=8'h1C→col 2,row 1; SC_SPACE=8'h29→col 8,row 0; SC_RET=8'h5A→col 7,row 0; E0+8'h75 (cursor up)→col 8,row 4.
- One sub-module, kb_map: purely combinational scancode→position table (case statement). The remaining pipeline and matrix live in kb_matrix.

Test Plan:
- Reset release with ps2_key[10]=1 already set → no evt_valid; col_sel=3 gives kb_rows=8'h00.
- Toggle with press, code 8'h1C, col_sel=3 → evt_valid at edge N+2; kb_rows=8'h02 at N+3. Release event → kb_rows=8'h00.
- Press SPACE and cursor-up (E0 75) on consecutive clocks, col_sel=9 → kb_rows=8'h11; both evt_valid pulses are present on consecutive cycles.
- Unmapped code 8'h07 pressed → no evt_valid; all columns read 8'h00.
- Hold A and RET, then pulse clr_all in the same cycle as a new SPACE press reaching stage 2 → all columns read 8'h00, SPACE not set.
- joy1=32'h11 with col_sel=8'h30 → kb_rows=8'h11. col_sel=8'h40 with joy2=0 → 8'h00. col_sel=8'h0A (beyond NUM_COLS) → 8'h00.
